// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control automaton: opcodes, ALU
// functs, FSM states and the decoded control word.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_COMMIT,
        S_WAIT,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [5:0] alu_funct;
        logic       rd_mux_s;
        logic       op2_mux_s;
        logic       write;
        logic       beq;
        logic       bne;
        logic       jump;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: opcode/funct -> control word plus a
// legal flag.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_word_t cw_o,
    output logic       legal_o
);

    always_comb begin
        cw_o    = '0;
        legal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
                        legal_o        = 1'b1;
                        cw_o.alu_funct = funct_i;
                        cw_o.rd_mux_s  = 1'b1;
                        cw_o.write     = 1'b1;
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            OP_ADDI: begin
                legal_o        = 1'b1;
                cw_o.alu_funct = F_ADD;
                cw_o.op2_mux_s = 1'b1;
                cw_o.write     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                legal_o        = 1'b1;
                cw_o.alu_funct = F_SUB;
                cw_o.beq       = (opcode_i == OP_BEQ);
                cw_o.bne       = (opcode_i == OP_BNE);
            end
            OP_J: begin
                legal_o        = 1'b1;
                cw_o.alu_funct = F_ADD;
                cw_o.jump      = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_aut.sv
// Multi-cycle control automaton: sequences FETCH/EXEC/COMMIT for the
// single-cycle datapath, with start, single-step, illegal halt and a counter.
module ctrl_aut
    import ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_INSTR = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_load,
    output logic             rd_mux_s,
    output logic             write,
    output logic             op2_mux_s,
    output logic [5:0]       alu_funct,
    output logic             branch_mux_s,
    output logic             j_mux_s,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    ctrl_word_t       cw_q, cw_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_word_t dec_cw;
    logic       dec_legal;

    ctrl_decoder u_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cw_o     (dec_cw),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cw_q      <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cw_q      <= cw_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // The decoded word is latched in FETCH in place of the raw opcode/funct,
    // so every output depends only on state_q and registered fields.
    always_comb begin
        state_d      = state_q;
        cw_d         = cw_q;
        zero_d       = zero_q;
        illegal_d    = illegal_q;
        cnt_d        = cnt_q;
        pc_load      = 1'b0;
        rd_mux_s     = 1'b0;
        write        = 1'b0;
        op2_mux_s    = 1'b0;
        alu_funct    = '0;
        branch_mux_s = 1'b0;
        j_mux_s      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                cw_d = dec_cw;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                rd_mux_s  = cw_q.rd_mux_s;
                op2_mux_s = cw_q.op2_mux_s;
                alu_funct = cw_q.alu_funct;
                zero_d    = zero;
                state_d   = S_COMMIT;
            end
            S_COMMIT: begin
                rd_mux_s     = cw_q.rd_mux_s;
                op2_mux_s    = cw_q.op2_mux_s;
                alu_funct    = cw_q.alu_funct;
                pc_load      = 1'b1;
                write        = cw_q.write;
                branch_mux_s = (cw_q.beq & zero_q) | (cw_q.bne & ~zero_q);
                j_mux_s      = cw_q.jump;
                cnt_d        = cnt_q + CNT_W'(1);
                if ((MAX_INSTR != 0) && (cnt_d == CNT_W'(MAX_INSTR))) begin
                    state_d = S_HALT;
                end else if (step_mode) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (step || !step_mode) state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_COMMIT);
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_aut.sv
// Scoreboard bench for ctrl_aut: the bench plays the datapath, a reference
// decoder predicts each COMMIT and a monitor checks every pc_load pulse.
module tb_ctrl_aut;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;

    logic        pc_load, rd_mux_s, write, op2_mux_s, branch_mux_s, j_mux_s;
    logic        busy, halted, illegal;
    logic [5:0]  alu_funct;
    logic [15:0] instr_count;

    logic        m_pc_load, m_rd_mux_s, m_write, m_op2_mux_s, m_branch_mux_s, m_j_mux_s;
    logic        m_busy, m_halted, m_illegal;
    logic [5:0]  m_alu_funct;
    logic [15:0] m_instr_count;

    ctrl_aut #(.CNT_W(16), .MAX_INSTR(0)) dut (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .opcode(opcode), .funct(funct), .zero(zero),
        .pc_load(pc_load), .rd_mux_s(rd_mux_s), .write(write), .op2_mux_s(op2_mux_s),
        .alu_funct(alu_funct), .branch_mux_s(branch_mux_s), .j_mux_s(j_mux_s),
        .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    ctrl_aut #(.CNT_W(16), .MAX_INSTR(2)) dut_max (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .opcode(opcode), .funct(funct), .zero(zero),
        .pc_load(m_pc_load), .rd_mux_s(m_rd_mux_s), .write(m_write), .op2_mux_s(m_op2_mux_s),
        .alu_funct(m_alu_funct), .branch_mux_s(m_branch_mux_s), .j_mux_s(m_j_mux_s),
        .busy(m_busy), .halted(m_halted), .illegal(m_illegal), .instr_count(m_instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        wr;
        logic        br;
        logic        jj;
        logic [5:0]  af;
        logic        rd;
        logic        o2;
        logic [15:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         exp_cnt = 0;
    logic [5:0] rtype_f [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-set rules written straight from the decode table.
    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output bit legal, output logic [5:0] af,
                                       output bit rd, output bit o2, output bit wr,
                                       output bit is_beq, output bit is_bne, output bit jj);
        legal = 0; af = '0; rd = 0; o2 = 0; wr = 0; is_beq = 0; is_bne = 0; jj = 0;
        if (op == 6'h00) begin
            legal = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
            af = fn; rd = 1; wr = 1;
        end else if (op == 6'h08) begin
            legal = 1; af = 6'h20; o2 = 1; wr = 1;
        end else if (op == 6'h04 || op == 6'h05) begin
            legal = 1; af = 6'h22; is_beq = (op == 6'h04); is_bne = (op == 6'h05);
        end else if (op == 6'h02) begin
            legal = 1; af = 6'h20; jj = 1;
        end
    endfunction

    task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
        int k;
        k = int'($urandom_range(0, 8));
        fn = 6'($urandom);
        if (k < 5) begin
            op = 6'h00;
            fn = rtype_f[k];
        end else if (k == 5) op = 6'h08;
        else if (k == 6) op = 6'h04;
        else if (k == 7) op = 6'h05;
        else op = 6'h02;
    endtask

    // Called at a negedge inside FETCH; returns at the negedge after COMMIT.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bit lg, rd, o2, wr, ib, inb, jj;
        logic [5:0] af;
        ref_decode(op, fn, lg, af, rd, o2, wr, ib, inb, jj);
        sb.push_back('{wr: wr, br: (ib & z) | (inb & ~z), jj: jj, af: af, rd: rd, o2: o2,
                       cnt: exp_cnt[15:0]});
        opcode = op; funct = fn; zero = 1'($urandom);
        chk("fetch_state", {busy, pc_load}, 2'b10);
        @(negedge clock);
        opcode = 6'($urandom); funct = 6'($urandom); zero = z;
        chk("exec_ctl", {busy, pc_load, write, alu_funct, rd_mux_s, op2_mux_s},
            {1'b1, 1'b0, 1'b0, af, rd, o2});
        @(negedge clock);
        opcode = 6'($urandom); funct = 6'($urandom); zero = ~z;
        chk("commit_pc_load", pc_load, 1'b1);
        @(negedge clock);
        exp_cnt++;
        chk("count_after", instr_count, exp_cnt[15:0]);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (pc_load) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pc_load: got=1 expected=0 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("commit_word", {write, branch_mux_s, j_mux_s, alu_funct, rd_mux_s,
                                        op2_mux_s, instr_count}, e);
                end
            end else begin
                chk("strobes_idle", {write, branch_mux_s, j_mux_s}, 3'b000);
            end
        end
    end

    logic [5:0] d_op [10] = '{6'h00, 6'h04, 6'h04, 6'h05, 6'h05, 6'h02, 6'h08, 6'h00, 6'h00, 6'h00};
    logic [5:0] d_fn [10] = '{6'h20, 6'h11, 6'h11, 6'h3F, 6'h00, 6'h15, 6'h33, 6'h22, 6'h25, 6'h2A};
    logic       d_z  [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

    initial begin
        logic [5:0] op, fn;

        repeat (3) @(negedge clock);
        chk("reset_ctl", {pc_load, rd_mux_s, write, op2_mux_s, alu_funct, branch_mux_s, j_mux_s}, '0);
        chk("reset_status", {busy, halted, illegal, instr_count}, '0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_no_start", busy, 1'b0);

        // start stays high through the run; only IDLE uses it
        start = 1'b1;
        @(negedge clock);
        chk("start_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_instr(d_op[i], d_fn[i], d_z[i]);
            if (i == 0) chk("max_after1", {m_halted, m_illegal, m_instr_count}, {2'b00, 16'd1});
            if (i == 1) chk("max_after2", {m_halted, m_illegal, m_instr_count}, {2'b10, 16'd2});
        end
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rand_instr(op, fn);
            run_instr(op, fn, 1'($urandom));
        end
        chk("max_still_halted", {m_halted, m_instr_count}, {1'b1, 16'd2});

        step_mode = 1'b1;
        rand_instr(op, fn);
        run_instr(op, fn, 1'($urandom));
        for (int i = 0; i < 10; i++) begin
            chk("wait_idle", {pc_load, busy, instr_count}, {2'b00, exp_cnt[15:0]});
            @(negedge clock);
        end
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        rand_instr(op, fn);
        run_instr(op, fn, 1'($urandom));
        for (int i = 0; i < 4; i++) begin
            chk("wait_after_step", {pc_load, busy, instr_count}, {2'b00, exp_cnt[15:0]});
            @(negedge clock);
        end
        step_mode = 1'b0;
        @(negedge clock);
        run_instr(6'h02, 6'h00, 1'b0);

        opcode = 6'h3F;
        @(negedge clock);
        chk("illegal_halt", {halted, illegal, busy, instr_count}, {3'b110, exp_cnt[15:0]});
        start = 1'b1; step = 1'b1;
        repeat (6) @(negedge clock);
        chk("halt_absorbing", {halted, illegal, busy, instr_count}, {3'b110, exp_cnt[15:0]});
        start = 1'b0; step = 1'b0;

        reset = 1'b0;
        @(negedge clock);
        exp_cnt = 0;
        chk("reset_clears", {halted, illegal, instr_count}, '0);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        opcode = 6'h00; funct = 6'h01;
        @(negedge clock);
        chk("illegal_funct", {halted, illegal, busy, instr_count}, {3'b110, 16'd0});

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        sb.push_back('{wr: 1'b1, br: 1'b0, jj: 1'b0, af: 6'h20, rd: 1'b1, o2: 1'b0, cnt: 16'd0});
        opcode = 6'h00; funct = 6'h20;
        @(negedge clock);
        opcode = 6'h3F;
        @(negedge clock);
        chk("pre_reset_commit", {pc_load, write}, 2'b11);
        #2 reset = 1'b0;
        #1 chk("async_reset_out", {pc_load, write, busy, rd_mux_s, alu_funct}, '0);
        @(negedge clock);
        chk("no_commit_on_reset", instr_count, 16'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_aut.md
Name: ctrl_aut

Overview:
Multi-cycle control automaton that sequences the single-cycle operative datapath (PC, register file, ALU, branch/jump muxes). It takes the datapath's opcode, funct and zero outputs and produces the datapath's control inputs. Each instruction is spread over FETCH/EXEC/COMMIT so that instruction memory and ALU have a full cycle to settle. It adds start, single-step, illegal-instruction halt and an instruction counter for bring-up.

Parameters:
CNT_W, 16, width of retired-instruction counter
MAX_INSTR, 0, halt after this many retired instructions; 0 = unlimited

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  leave IDLE, begin execution
step_mode  in  1  1 = stop in WAIT after every COMMIT
step  in  1  in WAIT, advance one instruction
opcode  in  6  instruction[31:26] from datapath
funct  in  6  instruction[5:0] from datapath
zero  in  1  ALU zero flag from datapath
pc_load  out  1  PC register load enable
rd_mux_s  out  1  0 = rt, 1 = rd as write address
write  out  1  register-file write enable
op2_mux_s  out  1  0 = rdata2, 1 = sign-extended immediate
alu_funct  out  6  ALU operation code
branch_mux_s  out  1  1 = select branch target
j_mux_s  out  1  1 = select jump target
busy  out  1  state is FETCH, EXEC or COMMIT
halted  out  1  state is HALT
illegal  out  1  sticky; halt caused by undecodable instruction
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, instr_count 0, latched fields cleared.
- States: IDLE, FETCH, EXEC, COMMIT, WAIT, HALT.
- IDLE: leave on start=1 -> FETCH. Otherwise stay.
- FETCH: latch opcode/funct into op_q/funct_q and decode them.
  - Illegal -> HALT, illegal=1.
  - Legal -> EXEC.
  - No datapath controls asserted.
- EXEC: drive rd_mux_s, op2_mux_s and alu_funct from the decoded word. Sample zero into zero_q. -> COMMIT.
- COMMIT: hold EXEC controls and assert pc_load=1.
  - write=1 for R-type and addi.
  - branch_mux_s = (beq & zero_q) | (bne & ~zero_q).
  - j_mux_s=1 for j.
  - instr_count += 1.
  - If MAX_INSTR!=0 and the new count equals MAX_INSTR -> HALT (illegal stays 0).
  - Else if step_mode=1 -> WAIT.
  - Else -> FETCH.
- WAIT: step=1 -> FETCH. If step_mode is cleared -> FETCH. All controls 0.
- HALT: absorbing; only reset exits. start and step are ignored.
- pc_load, write, branch_mux_s and j_mux_s are 1 only in COMMIT, each for exactly one cycle per instruction.
- Latency: 3 cycles per instruction in run mode; the first FETCH is the cycle after start is sampled.
- Decode (alu_funct / rd_mux_s / op2_mux_s / write):
  - op 0x00, funct in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}: funct / 1 / 0 / 1.
  - op 0x08 addi: 0x20 / 0 / 1 / 1.
  - op 0x04 beq, 0x05 bne: 0x22 / 0 / 0 / 0.
  - op 0x02 j: 0x20 / 0 / 0 / 0.
  - Any other opcode, or op 0x00 with any other funct: illegal.
- Controls are registered or derived only from state and latched fields. There is no combinational path from the opcode/funct/zero inputs to the outputs.
- Reset asserted mid-instruction (e.g. in COMMIT): outputs drop to 0 immediately, with no PC or register write on the following edge.
- start held high continuously: only the IDLE->FETCH transition uses it.

Decomposition:
- Package ctrl_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_J), funct constants (F_ADD, F_SUB, F_AND, F_OR, F_SLT), state encoding, control-word struct.
- Sub-module ctrl_decoder: combinational opcode/funct -> control word + legal flag. The FSM lives in ctrl_aut.

Test Plan:
- Reset: assert reset=0 in mid-run -> all outputs 0 immediately. Release, start=1 -> busy=1 on the next cycle, FETCH.
- R-type add (op 0x00, funct 0x20):
  - EXEC/COMMIT: alu_funct=0x20, rd_mux_s=1, op2_mux_s=0.
  - COMMIT: write=1 and pc_load=1 for one cycle; instr_count 0->1.
  - Next FETCH exactly 3 cycles after the previous FETCH.
- beq (0x04):
  - zero=1 in EXEC -> COMMIT branch_mux_s=1, write=0.
  - zero=0 -> branch_mux_s=0.
  - bne (0x05) with zero=0 -> branch_mux_s=1.
- j (0x02): COMMIT j_mux_s=1, pc_load=1, write=0.
- Illegal opcode 0x3F, or op 0x00 with funct 0x01 -> HALT.
  - halted=1, illegal=1, no pc_load pulse, instr_count unchanged.
  - start/step ignored until reset.
- Limits:
  - step_mode=1: after one COMMIT the FSM sits in WAIT with pc_load=0 for 10 cycles; a step pulse yields exactly one more instruction.
  - MAX_INSTR=2: halts after the 2nd COMMIT with illegal=0, instr_count=2.
